// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART transmit FIFO block:
//   UART_BYTE_W  - width of one UART character
//   WB_TIMEOUT   - cycles the launch FSM waits for the transmitter to raise
//                  busy before assuming it finished instantly
//   tx_state_e   - launch FSM state encoding
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;
  localparam int unsigned WB_TIMEOUT  = 2;
  localparam int unsigned WB_CNT_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with asynchronous (combinational) head read, suitable for
// distributed RAM. DEPTH must be a power of two (>= 2) so both pointers wrap
// by natural overflow.
//
// Ports
//   clk       clock, all state on rising edge
//   rst       synchronous active-high reset (pointers/level only)
//   push_i    write strobe; accepted when not full, or when a pop coincides
//   wdata_i   data to write
//   pop_i     read strobe; ignored when empty
//   flush_i   clears pointers and level; a push in the same cycle is ignored
//   rdata_o   current head entry
//   level_o   number of stored entries, 0..DEPTH
//   full_o    level_o == DEPTH
//   empty_o   level_o == 0
//   drop_o    a push was rejected this cycle because the FIFO was full
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic full, empty;
  logic push_ok, pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  assign pop_ok  = pop_i && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle:
  // the slot being written is the one being read out (wr_ptr == rd_ptr).
  assign push_ok = push_i && !flush_i && (!full || pop_ok);
  assign drop_o  = push_i && !flush_i && full && !pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// CPU-side byte FIFO feeding a UART transmitter. A small launch FSM pops the
// head byte into a holding register and issues a one-cycle launch pulse, then
// waits for the transmitter to go busy and come back idle before the next
// launch. A sticky overflow flag records pushes dropped while full.
//
// Launch FSM
//   state      | meaning
//   IDLE       | no byte in flight; pops head when FIFO non-empty and tx idle
//   LAUNCH     | uart_tx_en pulse with the holding register on uart_tx_data
//   WAIT_BUSY  | waiting for the transmitter to acknowledge with busy
//   WAIT_DONE  | waiting for the transmitter to drop busy
//
// Ports
//   clk           clock, all state on rising edge
//   rst           synchronous active-high reset
//   wr_en/wr_data CPU push strobe and byte
//   flush         clears FIFO contents; a byte already popped still goes out
//   ovf_clr       clears the sticky overflow flag
//   uart_tx_en    one-cycle launch pulse
//   uart_tx_data  holding register (valid with uart_tx_en, held otherwise)
//   uart_tx_busy  transmitter busy
//   level         bytes stored, 0..DEPTH
//   full/empty    level == DEPTH / level == 0
//   overflow      sticky: a push was dropped
//   idle          FIFO empty and launch FSM in IDLE
// ----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   flush,
  input  logic                   ovf_clr,
  output logic                   uart_tx_en,
  output logic [UART_BYTE_W-1:0] uart_tx_data,
  input  logic                   uart_tx_busy,
  output logic [LVL_W-1:0]       level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   idle
);

  tx_state_e              state_q, state_d;
  logic [UART_BYTE_W-1:0] hold_q, hold_d;
  logic [WB_CNT_W-1:0]    wb_cnt_q, wb_cnt_d;
  logic                   ovf_q, ovf_d;

  logic                   pop;
  logic                   tx_en;
  logic [UART_BYTE_W-1:0] fifo_rdata;
  logic                   fifo_empty;
  logic                   fifo_drop;

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .level_o (level),
    .full_o  (full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // The busy-wait timeout window is counted from the launch pulse, so the
  // LAUNCH cycle is the first of its WB_TIMEOUT cycles. With a transmitter
  // that never raises busy this gives exactly four cycles between launches.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wb_cnt_d = wb_cnt_q;
    pop      = 1'b0;
    tx_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !uart_tx_busy) begin
          pop      = 1'b1;
          hold_d   = fifo_rdata;
          wb_cnt_d = WB_CNT_W'(WB_TIMEOUT);
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_en    = 1'b1;
        wb_cnt_d = wb_cnt_q - WB_CNT_W'(1);
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (wb_cnt_q != '0) wb_cnt_d = wb_cnt_q - WB_CNT_W'(1);
        if (uart_tx_busy || (wb_cnt_q <= WB_CNT_W'(1))) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A drop in the same cycle as ovf_clr wins so the event is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_drop)    ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      wb_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wb_cnt_q <= wb_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign uart_tx_en   = tx_en;
  assign uart_tx_data = hold_q;
  assign empty        = fifo_empty;
  assign overflow     = ovf_q;
  assign idle         = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             flush = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             uart_tx_busy = 1'b0;
  logic             uart_tx_en;
  logic [7:0]       uart_tx_data;
  logic [LVL_W-1:0] level;
  logic             full, empty, overflow, idle;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .ovf_clr      (ovf_clr),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .idle         (idle)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Queue of stored bytes; a byte in flight blocks further pops until the
  // transmitter is seen idle at least three cycles after the pop.
  logic [7:0] mq[$];
  logic [7:0] m_hold = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_wait = 1'b0;
  int         m_since = 0;
  bit         started = 1'b0;

  initial begin : model
    bit pop, acc, drop;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_hold  = 8'h00;
        m_ovf   = 1'b0;
        m_wait  = 1'b0;
        m_since = 0;
      end else begin
        pop  = !m_wait && (mq.size() > 0) && !uart_tx_busy;
        acc  = wr_en && !flush && ((mq.size() < DEPTH) || pop);
        drop = wr_en && !flush && !acc;
        if (m_wait && m_since >= 3 && !uart_tx_busy) m_wait = 1'b0;
        if (m_since < 1000) m_since++;
        if (pop) begin
          m_hold  = mq.pop_front();
          m_wait  = 1'b1;
          m_since = 1;
        end
        if (flush)    mq.delete();
        else if (acc) mq.push_back(wr_data);
        if (drop)         m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
      end
      started = 1'b1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (started) begin
        cmp("tx_en",    uart_tx_en,   (m_wait && m_since == 1));
        cmp("tx_data",  uart_tx_data, m_hold);
        cmp("level",    level,        mq.size());
        cmp("full",     full,         (mq.size() == DEPTH));
        cmp("empty",    empty,        (mq.size() == 0));
        cmp("overflow", overflow,     m_ovf);
        cmp("idle",     idle,         (mq.size() == 0) && !m_wait);
      end
    end
  end

  // ---------------- transmitter model and stimulus ----------------
  // tx_mode: 0 = busy for tx_len cycles after each launch, 1 = never busy,
  //          2 = busy held high
  int         tx_mode = 1;
  int         tx_len = 10;
  int         busy_left = 0;
  logic [7:0] log_d[$];
  int         log_c[$];

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (uart_tx_en === 1'b1) begin
      log_d.push_back(uart_tx_data);
      log_c.push_back(cyc);
      busy_left = tx_len;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    case (tx_mode)
      1:       uart_tx_busy = 1'b0;
      2:       uart_tx_busy = 1'b1;
      default: uart_tx_busy = (busy_left > 0);
    endcase
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int k = 0;
    while (log_d.size() < n && k < budget) begin tick(); k++; end
    cmp({nm, "_launch_timeout"}, (log_d.size() >= n), 1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (idle !== 1'b1 && k < budget) begin tick(); k++; end
    cmp({nm, "_idle_timeout"}, idle, 1);
  endtask

  task automatic check_reset_vals(input string nm);
    cmp({nm, "_level"}, level, 0);
    cmp({nm, "_empty"}, empty, 1);
    cmp({nm, "_full"}, full, 0);
    cmp({nm, "_ovf"}, overflow, 0);
    cmp({nm, "_en"}, uart_tx_en, 0);
    cmp({nm, "_data"}, uart_tx_data, 8'h00);
    cmp({nm, "_idle"}, idle, 1);
  endtask

  logic [7:0] sent[$];

  initial begin : main
    int c0, p;
    // reset
    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // three bytes through a transmitter busy 10 cycles per byte
    tx_mode = 0; tx_len = 10;
    log_d.delete(); log_c.delete();
    push(8'h41); push(8'h42); push(8'h43);
    wait_log(3, 200, "abc");
    wait_idle(50, "abc");
    cmp("abc_n", log_d.size(), 3);
    if (log_d.size() == 3) begin
      cmp("abc_0", log_d[0], 8'h41);
      cmp("abc_1", log_d[1], 8'h42);
      cmp("abc_2", log_d[2], 8'h43);
    end
    cmp("abc_level", level, 0);

    // overflow with busy held high
    tx_mode = 2;
    tick();
    log_d.delete(); log_c.delete(); sent.delete();
    for (int i = 0; i < 17; i++) begin
      sent.push_back(8'($urandom));
      push(sent[i]);
    end
    cmp("ovf_level", level, 16);
    cmp("ovf_full", full, 1);
    cmp("ovf_flag", overflow, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    cmp("ovf_clr", overflow, 0);
    tx_mode = 0; tx_len = 3;
    wait_log(16, 600, "ovf_drain");
    wait_idle(100, "ovf_drain");
    repeat (20) tick();
    cmp("ovf_n", log_d.size(), 16);
    for (int i = 0; i < 16 && i < log_d.size(); i++) cmp("ovf_byte", log_d[i], sent[i]);

    // push into a full FIFO in the cycle of the pop
    tx_mode = 2;
    tick();
    log_d.delete(); log_c.delete(); sent.delete();
    for (int i = 0; i < 16; i++) begin
      sent.push_back(8'($urandom));
      push(sent[i]);
    end
    cmp("fullpop_pre", level, 16);
    tx_mode = 0; tx_len = 3;
    tick();
    sent.push_back(8'hEE);
    push(8'hEE);
    cmp("fullpop_level", level, 16);
    cmp("fullpop_ovf", overflow, 0);
    wait_log(17, 600, "fullpop");
    wait_idle(100, "fullpop");
    cmp("fullpop_n", log_d.size(), 17);
    for (int i = 0; i < 17 && i < log_d.size(); i++) cmp("fullpop_byte", log_d[i], sent[i]);

    // transmitter that never goes busy
    tx_mode = 1;
    log_d.delete(); log_c.delete();
    push(8'h10); push(8'h20); push(8'h30);
    wait_log(3, 60, "nobusy");
    wait_idle(20, "nobusy");
    if (log_c.size() >= 3) begin
      cmp("nobusy_gap1", log_c[1] - log_c[0], 4);
      cmp("nobusy_gap2", log_c[2] - log_c[1], 4);
    end

    // flush while the first of five bytes is in WAIT_DONE
    tx_mode = 0; tx_len = 10;
    log_d.delete(); log_c.delete();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    cmp("flush_pre", level, 4);
    flush = 1'b1; tick(); flush = 1'b0;
    cmp("flush_level", level, 0);
    cmp("flush_ovf", overflow, 0);
    repeat (40) tick();
    cmp("flush_n", log_d.size(), 1);
    if (log_d.size() >= 1) cmp("flush_byte", log_d[0], 8'hA1);
    cmp("flush_idle", idle, 1);

    // reset while the first of four bytes is in WAIT_DONE
    log_d.delete(); log_c.delete();
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    cmp("rstmid_pre", level, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_vals("rstmid");
    repeat (40) tick();
    cmp("rstmid_n", log_d.size(), 1);

    // randomized traffic
    for (int seg = 0; seg < 12; seg++) begin
      tx_mode = $urandom_range(0, 2);
      tx_len  = $urandom_range(0, 12);
      case ($urandom_range(0, 2))
        0:       p = 10;
        1:       p = 50;
        default: p = 90;
      endcase
      for (int i = 0; i < 250; i++) begin
        wr_en   = ($urandom_range(0, 99) < p);
        wr_data = 8'($urandom);
        flush   = ($urandom_range(0, 99) == 0);
        ovf_clr = ($urandom_range(0, 29) == 0);
        rst     = ($urandom_range(0, 399) == 0);
        tick();
      end
      wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
    end
    tx_mode = 0; tx_len = 2;
    wait_idle(600, "random_end");

    c0 = cyc;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
